// File: rtl/config_pkg.sv
// Shared constants and types for the FIFO read-side byte packer.
package config_pkg;

    localparam int DATA_W = 8;
    localparam int PACK   = 4;
    localparam int CNT_W  = 16;
    localparam int PC_W   = $clog2(PACK + 1);
    localparam int LI_W   = (PACK > 1) ? $clog2(PACK) : 1;

    typedef logic [DATA_W-1:0] lane_t;
    typedef lane_t [PACK-1:0]  word_t;
    typedef logic [PACK-1:0]   keep_t;
    typedef logic [PC_W-1:0]   pcnt_t;

    typedef enum logic {
        S_FILL,
        S_FLUSH
    } state_t;

endpackage

// File: rtl/pack_out_reg.sv
// Valid/ready output holding register for packed words.
module pack_out_reg
    import config_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  move,
    input  word_t in_data,
    input  keep_t in_keep,
    input  logic  in_last,
    input  logic  ready,
    output logic  valid,
    output word_t data,
    output keep_t keep,
    output logic  last,
    output logic  slot_free
);

    assign slot_free = !valid || ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            keep  <= '0;
            last  <= 1'b0;
        end else if (move) begin
            valid <= 1'b1;
            data  <= in_data;
            keep  <= in_keep;
            last  <= in_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a 1-cycle-latency FIFO and packs PACK of them per word,
// with flush-driven partial words carrying a keep mask and last flag.
module fifo_rd_packer
    import config_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    output logic                   fifo_rd,
    input  logic [DATA_W-1:0]      fifo_dout,
    input  logic                   fifo_empty,
    input  logic                   flush,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_W*PACK-1:0] m_data,
    output logic [PACK-1:0]        m_keep,
    output logic                   m_last,
    output logic [CNT_W-1:0]       word_cnt,
    output logic                   busy
);

    state_t state, state_n;
    pcnt_t  pack_cnt;
    pcnt_t  reserved;
    logic   inflight;
    word_t  lanes;
    word_t  mv_data;
    keep_t  mv_keep;
    word_t  out_data;
    logic   slot_free;
    logic   complete;
    logic   move;

    assign reserved = pack_cnt + pcnt_t'(inflight);
    assign complete = (pack_cnt == pcnt_t'(PACK))
                    || (state == S_FLUSH && !inflight && pack_cnt != '0);
    assign move = complete && slot_free;

    assign fifo_rd = !rst && !fifo_empty && state == S_FILL
                   && (reserved < pcnt_t'(PACK)
                       || (pack_cnt == pcnt_t'(PACK) && move));

    assign busy = (pack_cnt != '0) || inflight || (state == S_FLUSH);

    // Lanes beyond pack_cnt are masked so stale bytes never leak out.
    always_comb begin
        mv_data = '0;
        mv_keep = '0;
        for (int k = 0; k < PACK; k++) begin
            if (pcnt_t'(k) < pack_cnt) begin
                mv_data[k] = lanes[k];
                mv_keep[k] = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FILL:  if (flush && reserved != '0) state_n = S_FLUSH;
            S_FLUSH: if (move || reserved == '0) state_n = S_FILL;
            default: state_n = S_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FILL;
            pack_cnt <= '0;
            inflight <= 1'b0;
            lanes    <= '0;
            word_cnt <= '0;
        end else begin
            state    <= state_n;
            inflight <= fifo_rd;
            if (move) begin
                pack_cnt <= '0;
            end else if (inflight) begin
                lanes[pack_cnt[LI_W-1:0]] <= fifo_dout;
                pack_cnt <= pack_cnt + 1'b1;
            end
            if (m_valid && m_ready) word_cnt <= word_cnt + 1'b1;
        end
    end

    pack_out_reg u_out (
        .clk       (clk),
        .rst       (rst),
        .move      (move),
        .in_data   (mv_data),
        .in_keep   (mv_keep),
        .in_last   (state == S_FLUSH),
        .ready     (m_ready),
        .valid     (m_valid),
        .data      (out_data),
        .keep      (m_keep),
        .last      (m_last),
        .slot_free (slot_free)
    );

    assign m_data = out_data;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench: behavioural 1-cycle-latency FIFO feeding fifo_rd_packer.
module tb_fifo_rd_packer;
    import config_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_rd;
    lane_t       fifo_dout;
    logic        fifo_empty;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    keep_t       m_keep;
    logic        m_last;
    logic [15:0] word_cnt;
    logic        busy;

    always #5 clk = ~clk;

    fifo_rd_packer dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_last     (m_last),
        .word_cnt   (word_cnt),
        .busy       (busy)
    );

    // upstream FIFO model, one-cycle read latency
    lane_t      mem [16];
    logic [3:0] wp, rp;
    logic [4:0] fcnt;
    logic       wr = 1'b0;
    lane_t      din = '0;
    logic       do_rd;

    assign fifo_empty = (fcnt == 5'd0);
    assign do_rd = fifo_rd && !fifo_empty;

    always @(posedge clk) if (wr) mem[wp] <= din;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0; rp <= '0; fcnt <= '0; fifo_dout <= '0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (do_rd) begin
                fifo_dout <= mem[rp];
                rp <= rp + 1'b1;
            end
            fcnt <= fcnt + 5'(wr) - 5'(do_rd);
        end
    end

    // output collector and sticky protocol watchers
    logic [36:0] q [$];
    int          qcyc [$];
    int          cyc = 0;
    int          pops = 0;
    int          rd_empty_err = 0;
    int          stab_err = 0;
    logic        hold_prev = 1'b0;
    logic [36:0] prev_out = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (fifo_rd) pops++;
            if (fifo_rd && fifo_empty) rd_empty_err++;
            if (hold_prev && {m_data, m_keep, m_last} != prev_out) stab_err++;
            if (m_valid && m_ready) begin
                q.push_back({m_data, m_keep, m_last});
                qcyc.push_back(cyc);
            end
            hold_prev = m_valid && !m_ready;
            prev_out  = {m_data, m_keep, m_last};
        end else begin
            hold_prev = 1'b0;
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input lane_t b);
        wr = 1'b1;
        din = b;
        step();
        wr = 1'b0;
    endtask

    task automatic wait_words(input int n, input string tag);
        int t;
        t = 0;
        while (q.size() < n && t < 80) begin
            step();
            t++;
        end
        chk(tag, 64'(q.size()), 64'(n));
    endtask

    task automatic chk_word(input string tag, input int i,
                            input logic [31:0] d, input keep_t k,
                            input logic l);
        logic [36:0] w;
        w = (i < q.size()) ? q[i] : '1;
        chk({tag, "_data"}, 64'(w[36:5]), 64'(d));
        chk({tag, "_keep"}, 64'(w[4:1]), 64'(k));
        chk({tag, "_last"}, 64'(w[0]), 64'(l));
    endtask

    initial begin
        step();
        step();
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_keep", 64'(m_keep), 64'd0);
        chk("rst_last", 64'(m_last), 64'd0);
        chk("rst_cnt", 64'(word_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd", 64'(fifo_rd), 64'd0);
        rst = 1'b0;
        step();

        // single full word
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(1, "t1_n");
        repeat (6) step();
        chk("t1_only1", 64'(q.size()), 64'd1);
        chk_word("t1", 0, 32'h44332211, 4'b1111, 1'b0);
        chk("t1_cnt", 64'(word_cnt), 64'd1);
        q.delete(); qcyc.delete();

        // back-to-back throughput
        for (int i = 1; i <= 8; i++) push(lane_t'(i));
        wait_words(2, "t2_n");
        chk_word("t2a", 0, 32'h04030201, 4'b1111, 1'b0);
        chk_word("t2b", 1, 32'h08070605, 4'b1111, 1'b0);
        chk("t2_gap", 64'(qcyc[1] - qcyc[0]), 64'd5);
        chk("t2_cnt", 64'(word_cnt), 64'd3);
        repeat (4) step();
        q.delete(); qcyc.delete();

        // partial word by flush
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (6) step();
        chk("t3_pre", 64'(q.size()), 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words(1, "t3_n");
        chk_word("t3", 0, 32'h00C3B2A1, 4'b0111, 1'b1);
        step();
        chk("t3_busy", 64'(busy), 64'd0);
        chk("t3_valid", 64'(m_valid), 64'd0);
        q.delete(); qcyc.delete();

        // backpressure
        m_ready = 1'b0;
        pops = 0;
        for (int i = 0; i < 12; i++) push(lane_t'(8'h21 + i));
        repeat (30) step();
        chk("t4_none", 64'(q.size()), 64'd0);
        chk("t4_valid", 64'(m_valid), 64'd1);
        chk("t4_hold", 64'(m_data), 64'h24232221);
        chk("t4_pops", 64'(pops), 64'd8);
        chk("t4_full", 64'(dut.pack_cnt), 64'd4);
        chk("t4_stab", 64'(stab_err), 64'd0);
        m_ready = 1'b1;
        wait_words(3, "t4_n");
        chk_word("t4a", 0, 32'h24232221, 4'b1111, 1'b0);
        chk_word("t4b", 1, 32'h28272625, 4'b1111, 1'b0);
        chk_word("t4c", 2, 32'h2C2B2A29, 4'b1111, 1'b0);
        repeat (4) step();
        q.delete(); qcyc.delete();

        // flush with nothing buffered
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (8) step();
        chk("t5a_none", 64'(q.size()), 64'd0);
        chk("t5a_busy", 64'(busy), 64'd0);

        // flush while the single byte is in flight
        push(8'h5A);
        for (int t = 0; t < 10 && !fifo_rd; t++) step();
        chk("t5b_rd", 64'(fifo_rd), 64'd1);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words(1, "t5b_n");
        chk_word("t5b", 0, 32'h0000005A, 4'b0001, 1'b1);
        repeat (4) step();
        q.delete(); qcyc.delete();

        // async reset mid-fill
        push(8'h91); push(8'h92); push(8'h93);
        for (int t = 0; t < 10 && !(dut.pack_cnt == 2 && dut.inflight); t++)
            step();
        chk("t6_mid", 64'({dut.pack_cnt, dut.inflight}), 64'({3'd2, 1'b1}));
        rst = 1'b1;
        #1;
        chk("t6_rd", 64'(fifo_rd), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_cnt", 64'(word_cnt), 64'd0);
        chk("t6_out", 64'({m_valid, m_data, m_keep, m_last}), 64'd0);
        step();
        rst = 1'b0;
        step();
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        wait_words(1, "t6_n");
        chk_word("t6", 0, 32'h54535251, 4'b1111, 1'b0);
        chk("t6_cnt1", 64'(word_cnt), 64'd1);

        chk("rd_empty", 64'(rd_empty_err), 64'd0);
        chk("stable", 64'(stab_err), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the team's synchronous `fifo` (ports `rd`/`dout`/`empty`, one-cycle read latency).
- Pops bytes whenever space allows and packs PACK consecutive bytes into one wide word, first byte in the LSB lane.
- Presents each packed word on a valid/ready master stream.
- A flush request emits a partial word with a lane-keep mask and a last flag, so the downstream bus never waits on a stalled trickle of bytes.

Parameters:
- DATA_W, 8, width of one FIFO entry (bits).
- PACK, 4, FIFO entries per output word (≥2).
- CNT_W, 16, width of the emitted-word counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- fifo_rd  out  1  pop strobe to FIFO `rd`.
- fifo_dout  in  DATA_W  FIFO `dout`; valid the cycle after fifo_rd.
- fifo_empty  in  1  FIFO `empty`.
- flush  in  1  single-cycle request to emit the partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_W*PACK  packed word; lane k = bits [k*DATA_W +: DATA_W].
- m_keep  out  PACK  lane-valid mask.
- m_last  out  1  word produced by a flush.
- word_cnt  out  CNT_W  count of accepted output words; wraps.
- busy  out  1  pack register non-empty, a read is in flight, or flush pending.

Behaviour:
- Reset values: fifo_rd=0, m_valid=0, m_data=0, m_keep=0, m_last=0, word_cnt=0, busy=0. Internal state: pack_cnt=0, inflight=0, state=S_FILL.
- fifo_rd is forced to 0 while rst is high.
- Internal state:
  - pack_cnt (0..PACK): lanes captured.
  - inflight: registered copy of fifo_rd.
  - reserved = pack_cnt + inflight.
- Capture: when inflight=1, fifo_dout is written into lane pack_cnt and pack_cnt increments on that edge.
- Move (pack register → output register): occurs when the word is complete and the output slot is free (m_valid=0 or m_ready=1). The word is complete when:
  - pack_cnt==PACK, or
  - in S_FLUSH with inflight=0 and pack_cnt>0.
- On the move edge:
  - m_data takes the packed lanes; unfilled lanes are 0.
  - m_keep has bit k set for k<pack_cnt.
  - m_last=1 only for a flush word.
  - m_valid=1 and pack_cnt=0.
- Read issue (combinational): fifo_rd = !fifo_empty && state==S_FILL && (reserved<PACK || (pack_cnt==PACK && move)).
  - fifo_rd is never asserted while fifo_empty=1.
  - No lane is ever overwritten before its word has moved.
- Throughput: PACK bytes per PACK+1 cycles when the FIFO is never empty and m_ready=1.
- Output handshake:
  - A word transfers on m_valid && m_ready, and word_cnt increments on that edge.
  - m_valid clears unless a move happens the same cycle.
  - m_data, m_keep and m_last hold stable while m_valid && !m_ready.
- FSM:
  - S_FILL → S_FLUSH on flush when reserved>0.
  - flush with reserved==0 is ignored: no zero-keep word is emitted.
  - In S_FLUSH there are no new reads; the outstanding byte lands, then the partial word moves. Return to S_FILL on the move edge.
  - If pack_cnt reaches PACK while in S_FLUSH, the word is a normal full word: m_keep all ones, m_last=1.
  - flush while already in S_FLUSH has no effect.
- Stall: pack full and output slot occupied → pack register holds, no reads issued.
- Async reset mid-operation: all state clears immediately. An in-flight byte is discarded; the FIFO shares rst and clears too.

Decomposition:
- config_pkg holds:
  - constants DATA_W, PACK, CNT_W;
  - typedefs lane_t (logic [DATA_W-1:0]), word_t (lane_t [PACK-1:0]), keep_t (logic [PACK-1:0]);
  - enum state_t {S_FILL, S_FLUSH}.
- One sub-module, pack_out_reg: the valid/ready output holding register (data/keep/last, move input, slot-free output).
- Packing, issue logic and FSM stay in fifo_rd_packer.
- Bench instantiates the real `fifo` upstream, connected through the existing vif_if, plus fifo_rd_packer_sva bound alongside fifo_sva.

Test Plan:
- Push bytes 0x11,0x22,0x33,0x44 into the FIFO, m_ready=1 → exactly one word: m_data=0x44332211, m_keep=4'b1111, m_last=0, word_cnt=1. fifo_rd never high while empty.
- Push 0x01..0x08 back-to-back with FIFO never empty and m_ready=1 → words 0x04030201 then 0x08070605. The second word appears 5 cycles after the first.
- Push 0xA1,0xB2,0xC3, then pulse flush → one word: m_data=0x00C3B2A1, m_keep=4'b0111, m_last=1. busy drops the cycle after acceptance.
- Hold m_ready=0, push 12 bytes → one word held stable on the outputs, pack register full, fifo_rd stops after the 8th pop. Releasing m_ready drains all 3 words in order.
- Flush with nothing buffered, and flush in the same cycle as a pending read issue → in the first case no output word; in the second the in-flight byte is included, m_keep=4'b0001.
- Assert rst for 1 cycle mid-fill (2 lanes captured, read in flight) → all outputs return to reset values. The next 4 pushed bytes form a clean word with m_keep=4'b1111.
